// File: rtl/tt_pkg.sv
// Shared constants and FSM state type for the truth-table sweep engine.
package tt_pkg;

   localparam int MAX_N_IN  = 8;
   localparam int MAX_N_OUT = 8;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_SWEEP = 2'd1;
   localparam state_t ST_DONE  = 2'd2;

endpackage

// File: rtl/tt_lut.sv
// One 2^N_IN-bit truth table with a single write port and two
// combinational read ports.
module tt_lut #(
   parameter int N_IN = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            we,
   input  logic [N_IN-1:0] waddr,
   input  logic            wbit,
   input  logic [N_IN-1:0] raddr_a,
   input  logic [N_IN-1:0] raddr_b,
   output logic            rdata_a,
   output logic            rdata_b
);

   localparam int DEPTH = 1 << N_IN;

   logic [DEPTH-1:0] mem_q;
   logic [DEPTH-1:0] mem_d;

   always_comb begin
      mem_d = mem_q;
      if (we) begin
         mem_d[waddr] = wbit;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mem_q <= '0;
      end else begin
         mem_q <= mem_d;
      end
   end

   assign rdata_a = mem_q[raddr_a];
   assign rdata_b = mem_q[raddr_b];

endmodule

// File: rtl/tt_sweep_engine.sv
// Programmable truth-table engine: pipelined single-vector evaluation
// plus a handshaked sweep over every input vector.
module tt_sweep_engine
   import tt_pkg::*;
#(
   parameter int N_IN  = 4,
   parameter int N_OUT = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_we,
   input  logic [2:0]       cfg_sel,
   input  logic [N_IN-1:0]  cfg_addr,
   input  logic             cfg_bit,
   input  logic             ev_valid,
   input  logic [N_IN-1:0]  ev_in,
   output logic             ev_out_valid,
   output logic [N_OUT-1:0] ev_out,
   input  logic             start,
   output logic             row_valid,
   input  logic             row_ready,
   output logic [N_IN-1:0]  row_idx,
   output logic [N_OUT-1:0] row_out,
   output logic             busy,
   output logic             done
);

   localparam logic [N_IN-1:0] LAST_IDX = '1;

   state_t state_q;
   state_t state_d;

   logic [N_IN-1:0]  row_idx_q;
   logic [N_IN-1:0]  row_idx_d;
   logic             ev_out_valid_q;
   logic             ev_out_valid_d;
   logic [N_OUT-1:0] ev_out_q;
   logic [N_OUT-1:0] ev_out_d;
   logic [N_OUT-1:0] ev_rd;
   logic [N_OUT-1:0] row_rd;
   logic             hs;
   logic             cfg_ok;

   assign busy      = (state_q == ST_SWEEP);
   assign done      = (state_q == ST_DONE);
   assign row_valid = busy;
   assign hs        = row_valid & row_ready;
   // tables are frozen for the whole sweep
   assign cfg_ok    = cfg_we & ~busy;

   for (genvar k = 0; k < N_OUT; k++) begin : g_lut
      tt_lut #(
         .N_IN(N_IN)
      ) u_lut (
         .clk    (clk),
         .rst_n  (rst_n),
         .we     (cfg_ok && (cfg_sel == 3'(k))),
         .waddr  (cfg_addr),
         .wbit   (cfg_bit),
         .raddr_a(ev_in),
         .raddr_b(row_idx_q),
         .rdata_a(ev_rd[k]),
         .rdata_b(row_rd[k])
      );
   end

   always_comb begin
      state_d   = state_q;
      row_idx_d = row_idx_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d   = ST_SWEEP;
               row_idx_d = '0;
            end
         end
         ST_SWEEP: begin
            if (hs) begin
               if (row_idx_q == LAST_IDX) begin
                  state_d = ST_DONE;
               end else begin
                  row_idx_d = row_idx_q + N_IN'(1);
               end
            end
         end
         ST_DONE: begin
            state_d   = ST_IDLE;
            row_idx_d = '0;
         end
         default: begin
            state_d   = ST_IDLE;
            row_idx_d = '0;
         end
      endcase
   end

   // eval reads see the table contents before a same-edge write
   always_comb begin
      ev_out_valid_d = ev_valid;
      ev_out_d       = ev_valid ? ev_rd : ev_out_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         row_idx_q      <= '0;
         ev_out_valid_q <= 1'b0;
         ev_out_q       <= '0;
      end else begin
         state_q        <= state_d;
         row_idx_q      <= row_idx_d;
         ev_out_valid_q <= ev_out_valid_d;
         ev_out_q       <= ev_out_d;
      end
   end

   assign row_idx      = row_idx_q;
   assign row_out      = row_rd;
   assign ev_out_valid = ev_out_valid_q;
   assign ev_out       = ev_out_q;

endmodule
